// File: rtl/logo_pkg.sv
// Shared constants, colour type and palette for the logo overlay pipeline.
package logo_pkg;

    localparam int LOGO_W      = 480;
    localparam int LOGO_H      = 240;
    localparam int LOGO_PIXELS = LOGO_W * LOGO_H;
    localparam int FADE_MAX    = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Index 0 is the transparent key; its colour is never shown.
    localparam rgb_t [0:15] PALETTE = '{
        '{8'h00, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'hFF, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'hFF, 8'h80, 8'h00},
        '{8'hFF, 8'hFF, 8'h00},
        '{8'h80, 8'h00, 8'hFF},
        '{8'h00, 8'hFF, 8'hFF},
        '{8'h80, 8'h80, 8'h80},
        '{8'h40, 8'h40, 8'h40},
        '{8'hC0, 8'hC0, 8'hC0},
        '{8'hFF, 8'h40, 8'h80},
        '{8'h20, 8'h60, 8'hA0},
        '{8'hA0, 8'h60, 8'h20},
        '{8'h10, 8'h20, 8'h30}
    };

endpackage

// File: rtl/logo_palette.sv
// Combinational palette lookup: 4-bit colour index to 24-bit RGB.
module logo_palette
    import logo_pkg::*;
(
    input  logic [3:0] idx_i,
    output rgb_t       rgb_o
);

    assign rgb_o = PALETTE[idx_i];

endmodule

// File: rtl/logo_pixel_pipe.sv
// Three-stage logo overlay: ROM address issue, ROM data alignment, palette
// lookup with frame-based fade-in while the loading room is shown.
module logo_pixel_pipe
    import logo_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [2:0]  level_num,
    input  logic        is_logo,
    input  logic [17:0] logo_address,
    output logic [16:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        logo_on,
    output logic [7:0]  logo_r,
    output logic [7:0]  logo_g,
    output logic [7:0]  logo_b
);

    function automatic logic [7:0] fade_scale(input logic [7:0] ch, input logic [4:0] fade);
        logic [12:0] prod;
        prod = {5'd0, ch} * {8'd0, fade};
        return 8'(prod >> 4);
    endfunction

    logic [16:0] rom_addr_p1_q, rom_addr_p1_d;
    logic        vld_p1_q, vld_p1_d;
    logic        vld_p2_q;
    logic        logo_on_p3_q, logo_on_p3_d;
    rgb_t        rgb_p3_q, rgb_p3_d;
    logic [4:0]  fade_q, fade_d;
    rgb_t        pal_rgb;

    // Fade-in: clears whenever a real level is active, otherwise steps once per frame.
    always_comb begin
        fade_d = fade_q;
        if (level_num != 3'd0) begin
            fade_d = 5'd0;
        end else if (frame_start && (fade_q < 5'(FADE_MAX))) begin
            fade_d = fade_q + 5'd1;
        end
    end

    // ---- stage 1: range check and ROM address ----
    always_comb begin
        vld_p1_d      = is_logo && (logo_address < 18'(LOGO_PIXELS));
        rom_addr_p1_d = vld_p1_d ? logo_address[16:0] : 17'd0;
    end

    // ---- stage 3: palette lookup, transparency key, fade ----
    logo_palette u_palette (
        .idx_i (rom_data),
        .rgb_o (pal_rgb)
    );

    always_comb begin
        logo_on_p3_d = vld_p2_q && (rom_data != 4'd0);
        rgb_p3_d     = '0;
        if (logo_on_p3_d) begin
            rgb_p3_d.r = fade_scale(pal_rgb.r, fade_q);
            rgb_p3_d.g = fade_scale(pal_rgb.g, fade_q);
            rgb_p3_d.b = fade_scale(pal_rgb.b, fade_q);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_p1_q <= '0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            logo_on_p3_q  <= 1'b0;
            rgb_p3_q      <= '0;
            fade_q        <= '0;
        end else begin
            rom_addr_p1_q <= rom_addr_p1_d;
            vld_p1_q      <= vld_p1_d;
            // ---- stage 2: valid waits one cycle for the synchronous ROM ----
            vld_p2_q      <= vld_p1_q;
            logo_on_p3_q  <= logo_on_p3_d;
            rgb_p3_q      <= rgb_p3_d;
            fade_q        <= fade_d;
        end
    end

    assign rom_addr = rom_addr_p1_q;
    assign logo_on  = logo_on_p3_q;
    assign logo_r   = rgb_p3_q.r;
    assign logo_g   = rgb_p3_q.g;
    assign logo_b   = rgb_p3_q.b;

endmodule

// File: tb/tb_logo_pixel_pipe.sv
// Directed bench for logo_pixel_pipe with a synchronous sprite ROM model.
module tb_logo_pixel_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [2:0]  level_num;
    logic        is_logo;
    logic [17:0] logo_address;
    logic [16:0] rom_addr;
    logic [3:0]  rom_data;
    logic        logo_on;
    logic [7:0]  logo_r, logo_g, logo_b;

    int checks   = 0;
    int failures = 0;

    logo_pixel_pipe dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .level_num    (level_num),
        .is_logo      (is_logo),
        .logo_address (logo_address),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .logo_on      (logo_on),
        .logo_r       (logo_r),
        .logo_g       (logo_g),
        .logo_b       (logo_b)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents: address 1000 holds index 5, elsewhere a simple nibble hash.
    function automatic logic [3:0] rom_fn(input logic [16:0] a);
        if (a == 17'd1000) return 4'd5;
        return a[3:0] ^ a[7:4];
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    function automatic logic [23:0] pal_fn(input logic [3:0] i);
        case (i)
            4'd0:  return 24'h000000;
            4'd1:  return 24'hFFFFFF;
            4'd2:  return 24'hFF0000;
            4'd3:  return 24'h00FF00;
            4'd4:  return 24'h0000FF;
            4'd5:  return 24'hFF8000;
            4'd6:  return 24'hFFFF00;
            4'd7:  return 24'h8000FF;
            4'd8:  return 24'h00FFFF;
            4'd9:  return 24'h808080;
            4'd10: return 24'h404040;
            4'd11: return 24'hC0C0C0;
            4'd12: return 24'hFF4080;
            4'd13: return 24'h2060A0;
            4'd14: return 24'hA06020;
            default: return 24'h102030;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        is_logo      = 1'b0;
        logo_address = 18'd0;
        frame_start  = 1'b0;
    endtask

    task automatic set_fade(input int n);
        level_num = 3'd1;
        tick();
        level_num = 3'd0;
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        level_num = 3'd0;
        idle();
        repeat (2) tick();
        checks++;
        if (rom_addr !== 17'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++;
        if ({logo_on, logo_r, logo_g, logo_b} !== 25'd0) begin
            failures++; $display("FAIL reset_outputs got on=%0b rgb=%h%h%h exp on=0 rgb=000000", logo_on, logo_r, logo_g, logo_b);
        end
        checks++;
        if (dut.fade_q !== 5'd0) begin failures++; $display("FAIL reset_fade got=%0d exp=0", dut.fade_q); end
        Reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (logo_on !== 1'b0) begin failures++; $display("FAIL reset_idle_on got=%0b exp=0", logo_on); end
    endtask

    task automatic test_fade_ramp();
        level_num = 3'd0;
        for (int i = 1; i <= 17; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            checks++;
            if (dut.fade_q !== 5'((i > 16) ? 16 : i)) begin
                failures++; $display("FAIL fade_ramp pulse=%0d got=%0d exp=%0d", i, dut.fade_q, (i > 16) ? 16 : i);
            end
            tick();
        end
    endtask

    task automatic one_pixel(input string name, input logic [17:0] addr, input logic [16:0] exp_addr,
                             input logic exp_on, input logic [23:0] exp_rgb);
        is_logo      = 1'b1;
        logo_address = addr;
        tick();
        idle();
        checks++;
        if (rom_addr !== exp_addr) begin failures++; $display("FAIL %s_rom_addr got=%0d exp=%0d", name, rom_addr, exp_addr); end
        tick();
        checks++;
        if (logo_on !== 1'b0) begin failures++; $display("FAIL %s_early_on got=%0b exp=0", name, logo_on); end
        tick();
        checks++;
        if ({logo_on, logo_r, logo_g, logo_b} !== {exp_on, exp_rgb}) begin
            failures++; $display("FAIL %s_out got on=%0b rgb=%h%h%h exp on=%0b rgb=%h", name, logo_on, logo_r, logo_g, logo_b, exp_on, exp_rgb);
        end
    endtask

    task automatic test_latency();
        set_fade(16);
        one_pixel("latency_full", 18'd1000, 17'd1000, 1'b1, 24'hFF8000);
    endtask

    task automatic test_scaling();
        set_fade(8);
        one_pixel("scale_half", 18'd1000, 17'd1000, 1'b1, 24'h7F4000);
        set_fade(4);
        one_pixel("scale_quarter", 18'd12, 17'd12, 1'b1, 24'h3F1020);
    endtask

    task automatic test_transparency();
        set_fade(16);
        one_pixel("idx0_transparent", 18'd17, 17'd17, 1'b0, 24'h000000);
        one_pixel("out_of_range", 18'd115200, 17'd0, 1'b0, 24'h000000);
        one_pixel("last_in_range", 18'd115199, 17'd115199, 1'b0, 24'h000000);
        is_logo      = 1'b0;
        logo_address = 18'd1000;
        tick();
        idle();
        checks++;
        if (rom_addr !== 17'd0) begin failures++; $display("FAIL not_logo_rom_addr got=%0d exp=0", rom_addr); end
        repeat (2) tick();
        checks++;
        if (logo_on !== 1'b0) begin failures++; $display("FAIL not_logo_on got=%0b exp=0", logo_on); end
    endtask

    task automatic test_precedence();
        set_fade(9);
        checks++;
        if (dut.fade_q !== 5'd9) begin failures++; $display("FAIL precedence_setup got=%0d exp=9", dut.fade_q); end
        frame_start = 1'b1;
        level_num   = 3'd2;
        tick();
        frame_start = 1'b0;
        level_num   = 3'd0;
        checks++;
        if (dut.fade_q !== 5'd0) begin failures++; $display("FAIL precedence_clear got=%0d exp=0", dut.fade_q); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] a;
        logic [3:0]  idx;
        logic [23:0] exp_rgb;
        logic        exp_on;
        set_fade(16);
        for (int k = 0; k < 482; k++) begin
            if (k < 480) begin
                is_logo      = 1'b1;
                logo_address = 18'(2000 + k);
            end else begin
                idle();
            end
            tick();
            if (k >= 2) begin
                a       = 17'(2000 + k - 2);
                idx     = rom_fn(a);
                exp_on  = (idx != 4'd0);
                exp_rgb = exp_on ? pal_fn(idx) : 24'h000000;
                checks++;
                if ({logo_on, logo_r, logo_g, logo_b} !== {exp_on, exp_rgb}) begin
                    failures++;
                    $display("FAIL stream addr=%0d got on=%0b rgb=%h%h%h exp on=%0b rgb=%h", a, logo_on, logo_r, logo_g, logo_b, exp_on, exp_rgb);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_fade(16);
        for (int k = 0; k < 10; k++) begin
            is_logo      = 1'b1;
            logo_address = 18'(1000 + k);
            tick();
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({rom_addr, logo_on, logo_r, logo_g, logo_b} !== 42'd0) begin
            failures++; $display("FAIL midreset_outputs got addr=%0d on=%0b rgb=%h%h%h exp all 0", rom_addr, logo_on, logo_r, logo_g, logo_b);
        end
        checks++;
        if (dut.fade_q !== 5'd0) begin failures++; $display("FAIL midreset_fade got=%0d exp=0", dut.fade_q); end
        idle();
        #1 Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (logo_on !== 1'b0) begin failures++; $display("FAIL postreset_idle cycle=%0d got=%0b exp=0", k, logo_on); end
        end
        one_pixel("postreset_first", 18'd1000, 17'd1000, 1'b1, 24'h000000);
    endtask

    initial begin
        Reset        = 1'b1;
        level_num    = 3'd0;
        is_logo      = 1'b0;
        logo_address = 18'd0;
        frame_start  = 1'b0;
        test_reset();
        test_fade_ramp();
        test_latency();
        test_scaling();
        test_transparency();
        test_precedence();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
